// File: rtl/apb_v2_master.sv
// APB v2 requester: turns single-beat valid/ready commands into APB SETUP/ACCESS
// transfers and returns one registered response per command (data or timeout error).
module apb_v2_master #(
    parameter int addr_width     = 2,
    parameter int mem_width      = 4,
    parameter int timeout_cycles = 16
) (
    input  logic                  pclk,
    input  logic                  prst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [addr_width-1:0] cmd_addr,
    input  logic [mem_width-1:0]  cmd_wdata,
    output logic                  rsp_valid,
    output logic [mem_width-1:0]  rsp_rdata,
    output logic                  rsp_err,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [addr_width-1:0] paddr,
    output logic [mem_width-1:0]  pwdata,
    input  logic                  pready,
    input  logic [mem_width-1:0]  prdata
);

    localparam int CW = $clog2(timeout_cycles + 1);
    localparam logic [CW-1:0] WAIT_MAX = CW'(timeout_cycles - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  pwrite_q, pwrite_d;
    logic [addr_width-1:0] paddr_q, paddr_d;
    logic [mem_width-1:0]  pwdata_q, pwdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [mem_width-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;

    always_ff @(posedge pclk or negedge prst) begin
        if (!prst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        cmd_ready   = 1'b0;

        case (state_q)
            IDLE: cmd_ready = 1'b1;
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (pready) begin
                    cmd_ready   = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = pwrite_q ? '0 : prdata;
                    state_d     = IDLE;
                end else if (cnt_q == WAIT_MAX) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Acceptance overrides the IDLE return so completions chain straight into SETUP.
        if (cmd_valid && cmd_ready) begin
            pwrite_d = cmd_write;
            paddr_d  = cmd_addr;
            pwdata_d = cmd_wdata;
            cnt_d    = '0;
            state_d  = SETUP;
        end
    end

    assign psel      = (state_q != IDLE);
    assign penable   = (state_q == ACCESS);
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_v2_master.sv
// Directed + randomized bench for apb_v2_master with a configurable APB completer
// and a transaction-level reference model (latency, error, data per command).
module tb_apb_v2_master;

    localparam int T = 4;
    localparam int M_REG = 0, M_ONE = 1, M_ZERO = 2, M_RAND = 3;

    logic       pclk, prst;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [1:0] cmd_addr;
    logic [3:0] cmd_wdata;
    logic       rsp_valid, rsp_err;
    logic [3:0] rsp_rdata;
    logic       psel, penable, pwrite, pready;
    logic [1:0] paddr;
    logic [3:0] pwdata, prdata;

    int checks = 0;
    int errors = 0;
    int mode   = M_ONE;
    int wait_n = 0;

    logic [3:0] mem       [4] = '{default: 4'd0};
    logic [3:0] model_mem [4] = '{default: 4'd0};
    logic       preg = 1'b0;
    int         acc_cnt = 0;

    apb_v2_master #(.addr_width(2), .mem_width(4), .timeout_cycles(T)) dut (
        .pclk(pclk), .prst(prst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pready(pready), .prdata(prdata)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Completer: storage plus selectable pready behaviour.
    always @(posedge pclk) begin
        preg    <= psel & penable & ~preg;
        acc_cnt <= (psel && penable) ? acc_cnt + 1 : 0;
        if (psel && penable && pready && pwrite) mem[paddr] <= pwdata;
    end

    always_comb begin
        pready = 1'b0;
        case (mode)
            M_REG:   pready = preg;
            M_ONE:   pready = 1'b1;
            M_ZERO:  pready = 1'b0;
            default: pready = psel & penable & (acc_cnt >= wait_n);
        endcase
    end
    assign prdata = mem[paddr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One command; waits = completer wait cycles before pready (>= T means never in time).
    task automatic do_cmd(input logic w, input logic [1:0] a, input logic [3:0] d, input int waits);
        int n, lat, pc, exp_lat;
        logic exp_err;
        logic [3:0] exp_rd;
        exp_err = (waits >= T);
        exp_lat = exp_err ? T + 1 : waits + 2;
        exp_rd  = (w || exp_err) ? 4'd0 : model_mem[a];
        if (w && !exp_err) model_mem[a] = d;

        @(negedge pclk);
        cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge pclk); n++; end
        chk("accept_bound", 32'(n < 50), 1);
        @(posedge pclk);
        @(negedge pclk);
        cmd_valid = 1'b0;
        chk("setup_paddr", 32'(paddr), 32'(a));
        chk("setup_pwrite", 32'(pwrite), 32'(w));
        chk("setup_penable", 32'(penable), 0);
        if (w) chk("setup_pwdata", 32'(pwdata), 32'(d));
        lat = 0; pc = 0;
        while (!rsp_valid && lat < 50) begin
            if (psel) pc++;
            @(posedge pclk); lat++;
            @(negedge pclk);
        end
        chk("rsp_latency", lat, exp_lat);
        chk("psel_cycles", pc, exp_lat);
        chk("rsp_err", 32'(rsp_err), 32'(exp_err));
        chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
        chk("post_psel", 32'(psel), 0);
        chk("post_ready", 32'(cmd_ready), 1);
        @(negedge pclk);
        chk("rsp_one_cycle", 32'(rsp_valid), 0);
    endtask

    initial begin
        int n;
        prst = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        #12;
        chk("rst_psel", 32'(psel), 0);
        chk("rst_penable", 32'(penable), 0);
        chk("rst_pwrite", 32'(pwrite), 0);
        chk("rst_paddr", 32'(paddr), 0);
        chk("rst_pwdata", 32'(pwdata), 0);
        chk("rst_rsp", {29'd0, rsp_valid, rsp_err, 1'b0} | 32'(rsp_rdata), 0);
        @(negedge pclk);
        prst = 1'b1;
        #1 chk("rst_ready", 32'(cmd_ready), 1);

        // Registered-pready completer: write then read.
        mode = M_REG;
        do_cmd(1'b1, 2'd2, 4'hA, 1);
        do_cmd(1'b0, 2'd2, 4'h0, 1);

        // pready tied high, incl. stale pready in IDLE/SETUP.
        mode = M_ONE;
        do_cmd(1'b1, 2'd1, 4'h5, 0);
        do_cmd(1'b0, 2'd1, 4'h0, 0);

        // Back-to-back writes with cmd_valid held.
        mode = M_REG;
        @(negedge pclk);
        for (int i = 0; i < 4; i++) begin
            cmd_write = 1'b1; cmd_addr = i[1:0]; cmd_wdata = 4'(i + 1); cmd_valid = 1'b1;
            model_mem[i] = 4'(i + 1);
            n = 0;
            while (!cmd_ready && n < 50) begin @(negedge pclk); n++; end
            chk("b2b_accept_bound", 32'(n < 50), 1);
            @(posedge pclk);
            @(negedge pclk);
            chk("b2b_setup_psel", 32'(psel), 1);
            chk("b2b_setup_penable", 32'(penable), 0);
            if (i > 0) begin
                chk("b2b_rsp_valid", 32'(rsp_valid), 1);
                chk("b2b_rsp_err", 32'(rsp_err), 0);
            end
            if (i == 3) cmd_valid = 1'b0;
            @(negedge pclk);
            chk("b2b_access_psel", 32'(psel), 1);
            chk("b2b_access_penable", 32'(penable), 1);
        end
        n = 0;
        while (!rsp_valid && n < 20) begin @(negedge pclk); n++; end
        chk("b2b_last_rsp", 32'(rsp_valid), 1);
        for (int a = 0; a < 4; a++) do_cmd(1'b0, a[1:0], 4'h0, 1);

        // Timeout: pready never arrives.
        mode = M_ZERO;
        do_cmd(1'b1, 2'd0, 4'hF, 99);
        do_cmd(1'b0, 2'd3, 4'h0, 99);

        // Asynchronous reset in ACCESS.
        @(negedge pclk);
        cmd_write = 1'b1; cmd_addr = 2'd1; cmd_wdata = 4'h9; cmd_valid = 1'b1;
        @(posedge pclk);
        @(negedge pclk);
        cmd_valid = 1'b0;
        @(posedge pclk);
        #2 prst = 1'b0;
        #1;
        chk("arst_psel", 32'(psel), 0);
        chk("arst_penable", 32'(penable), 0);
        for (int c = 0; c < 2; c++) begin
            @(negedge pclk);
            chk("arst_no_rsp", 32'(rsp_valid), 0);
        end
        chk("arst_paddr", 32'(paddr), 0);
        @(posedge pclk);
        #3 prst = 1'b1;
        @(negedge pclk);
        chk("arst_no_rsp_after", 32'(rsp_valid), 0);
        mode = M_REG;
        do_cmd(1'b1, 2'd3, 4'h7, 1);
        do_cmd(1'b0, 2'd3, 4'h0, 1);

        // Randomized commands against random completer wait states.
        mode = M_RAND;
        repeat (25) begin
            logic w;
            logic [1:0] a;
            logic [3:0] d;
            w = 1'($urandom_range(0, 1));
            a = 2'($urandom_range(0, 3));
            d = 4'($urandom_range(0, 15));
            wait_n = int'($urandom_range(0, 5));
            do_cmd(w, a, d, wait_n);
        end
        mode = M_ONE;
        for (int a = 0; a < 4; a++) do_cmd(1'b0, a[1:0], 4'h0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
